dmx_slot_pwm: RTL

Downstream consumer of the DMX receiver: takes the per-slot byte stream and end-of-frame strobe, captures NUM_CH consecutive slots starting at a configurable DMX address, and commits them atomically on a valid frame. It drives one glitch-free 8-bit PWM output per channel for LED dimming. It also flags DMX signal loss.

---
 rtl/dmx_slot_pwm.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/dmx_slot_pwm.sv
// DMX slot capture with atomic frame commit, glitch-free 8-bit PWM per channel and signal-loss detection.
// Build option: define DMX_HOLD_LAST_EN to keep the last levels on signal loss instead of blanking.
module dmx_slot_pwm #(
  parameter int CLK_FREQ = 12000000,
  parameter int NUM_CH   = 8,
  parameter int PWM_DIV  = 16,
  parameter int LOSS_MS  = 1000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              slot_valid,
  input  logic [9:0]        slot_index,
  input  logic [7:0]        slot_data,
  input  logic              frame_end,
  input  logic [8:0]        start_addr,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              signal_ok,
  output logic [7:0]        frame_count
);

  localparam int LOSS_CYC = (CLK_FREQ / 1000) * LOSS_MS;
  localparam int LT_W     = $clog2(LOSS_CYC + 1);
  localparam int PS_W     = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

`ifdef DMX_HOLD_LAST_EN
  localparam bit HOLD_LAST = 1'b1;
`else
  localparam bit HOLD_LAST = 1'b0;
`endif

  typedef enum logic [1:0] {WAIT_SC, COLLECT, DISCARD} state_t;

  state_t            state_reg, state_next;
  logic [8:0]        base_reg, base_next;
  logic [9:0]        prev_reg, prev_next;
  logic [NUM_CH-1:0] mask_reg, mask_next;
  logic              wr_en;
  logic [CH_W-1:0]   wr_ch;
  logic              commit;
  logic [10:0]       offset;
  logic              in_window;

  logic [LT_W-1:0]   loss_reg;
  logic              expire;
  logic [PS_W-1:0]   presc_reg;
  logic              tick;
  logic [7:0]        cnt_reg;
  logic              wrap;
  logic [NUM_CH-1:0] pwm_next;

  assign offset    = {1'b0, slot_index} - {2'b00, base_reg};
  assign in_window = (slot_index >= {1'b0, base_reg}) && (offset < 11'(NUM_CH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= WAIT_SC;
      base_reg  <= 9'd1;
      prev_reg  <= '0;
      mask_reg  <= '0;
    end else begin
      state_reg <= state_next;
      base_reg  <= base_next;
      prev_reg  <= prev_next;
      mask_reg  <= mask_next;
    end
  end

  // A slot arriving with frame_end is applied first, so commit looks at the post-slot state.
  always_comb begin
    state_next = state_reg;
    base_next  = base_reg;
    prev_next  = prev_reg;
    mask_next  = mask_reg;
    wr_en      = 1'b0;
    wr_ch      = '0;
    commit     = 1'b0;
    if (slot_valid) begin
      if (slot_index == 10'd0) begin
        base_next  = (start_addr == 9'd0) ? 9'd1 : start_addr;
        prev_next  = '0;
        mask_next  = '0;
        state_next = (slot_data == 8'h00) ? COLLECT : DISCARD;
      end else if (state_reg == COLLECT) begin
        if (slot_index <= prev_reg || slot_index > 10'd512) begin
          state_next = DISCARD;
        end else begin
          prev_next = slot_index;
          if (in_window) begin
            wr_en            = 1'b1;
            wr_ch            = offset[CH_W-1:0];
            mask_next[wr_ch] = 1'b1;
          end
        end
      end
    end
    if (frame_end) begin
      commit     = (state_next == COLLECT);
      state_next = WAIT_SC;
    end
  end

  // Loss timer saturates; a commit in the expiry cycle takes priority.
  assign expire = !commit && (loss_reg == LT_W'(LOSS_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      loss_reg    <= '0;
      signal_ok   <= 1'b0;
      frame_count <= 8'd0;
    end else begin
      if (commit) begin
        loss_reg    <= '0;
        signal_ok   <= 1'b1;
        frame_count <= frame_count + 8'd1;
      end else begin
        if (loss_reg != LT_W'(LOSS_CYC))
          loss_reg <= loss_reg + LT_W'(1);
        if (expire)
          signal_ok <= 1'b0;
      end
    end
  end

  assign tick = (presc_reg == PS_W'(PWM_DIV - 1));
  assign wrap = tick && (cnt_reg == 8'd254);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_reg <= '0;
      cnt_reg   <= 8'd0;
    end else begin
      presc_reg <= tick ? '0 : presc_reg + PS_W'(1);
      if (tick)
        cnt_reg <= wrap ? 8'd0 : cnt_reg + 8'd1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [7:0] shadow_reg;
      logic [7:0] active_reg;
      logic [7:0] duty_reg;
      logic       hit;
      logic [7:0] shadow_eff;

      assign hit        = wr_en && (wr_ch == CH_W'(gi));
      assign shadow_eff = hit ? slot_data : shadow_reg;
      assign pwm_next[gi] = (cnt_reg < duty_reg);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          shadow_reg <= 8'd0;
          active_reg <= 8'd0;
          duty_reg   <= 8'd0;
        end else begin
          if (hit)
            shadow_reg <= slot_data;
          if (commit && mask_next[gi])
            active_reg <= shadow_eff;
          else if (expire && !HOLD_LAST)
            active_reg <= 8'd0;
          // Duty only changes at the period boundary so a pulse is never cut short or doubled.
          if (wrap)
            duty_reg <= active_reg;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      pwm_out <= '0;
    else
      pwm_out <= pwm_next;
  end

endmodule
